// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin arbiter driving the select of an 8-input mux
module mux8_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic [2:0] sel,
    output logic [3:0] hold_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic [2:0] sel_q, sel_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [2:0] last_q, last_d;

    // Returns {found, index} of the first set bit searching base+1 .. base+8.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int k = 8; k >= 1; k--) begin
            idx = base + k[2:0];
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic [7:0] others;
    logic [3:0] pick_all;
    logic [3:0] pick_oth;
    logic       new_grant;
    logic [2:0] new_idx;
    logic       go_idle;

    always_comb begin
        others   = req & ~(8'b1 << last_q);
        pick_all = rr_pick(req, last_q);
        pick_oth = rr_pick(others, last_q);

        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        sel_d       = sel_q;
        hold_cnt_d  = hold_cnt_q;
        last_d      = last_q;
        new_grant   = 1'b0;
        new_idx     = pick_oth[2:0];
        go_idle     = 1'b0;

        // In GRANT the owner is always last_q, so searching from last_q starts at owner+1.
        case (state_q)
            IDLE: begin
                if (pick_all[3]) begin
                    new_grant = 1'b1;
                    new_idx   = pick_all[2:0];
                end
            end
            GRANT: begin
                if (!req[last_q]) begin
                    if (pick_oth[3]) begin
                        new_grant = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (hold_cnt_q < HOLD_LIM) begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end else if (pick_oth[3]) begin
                    new_grant = 1'b1;
                end else begin
                    hold_cnt_d = 4'd1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (new_grant) begin
            state_d     = GRANT;
            gnt_d       = 8'b1 << new_idx;
            gnt_valid_d = 1'b1;
            sel_d       = new_idx;
            hold_cnt_d  = 4'd1;
            last_d      = new_idx;
        end else if (go_idle) begin
            // sel keeps the previous owner so the mux output stays stable.
            state_d     = IDLE;
            gnt_d       = 8'b0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 8'b0;
            gnt_valid_q <= 1'b0;
            sel_q       <= 3'd0;
            hold_cnt_q  <= 4'd0;
            last_q      <= 3'd7;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            sel_q       <= sel_d;
            hold_cnt_q  <= hold_cnt_d;
            last_q      <= last_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign sel       = sel_q;
    assign hold_cnt  = hold_cnt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - directed self-checking bench for mux8_rr_arbiter
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] sel;
    logic [3:0] hold_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    mux8_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .sel       (sel),
        .hold_cnt  (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] e_gnt, input logic e_valid,
                             input logic [2:0] e_sel, input logic [3:0] e_hold);
        check({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(e_valid));
        check({tag, ".sel"}, 32'(sel), 32'(e_sel));
        check({tag, ".hold_cnt"}, 32'(hold_cnt), 32'(e_hold));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int         w_sel[8]  = '{6, 6, 6, 0, 0, 0, 0, 6};
    int         w_hold[8] = '{2, 3, 4, 1, 2, 3, 4, 1};
    logic [2:0] s;

    initial begin
        rst = 1'b1;
        req = 8'hFF;

        // Reset with all requests pending, then first arbitration favours 0.
        tick();
        check_out("rst_c1", 8'h00, 1'b0, 3'd0, 4'd0);
        tick();
        check_out("rst_c2", 8'h00, 1'b0, 3'd0, 4'd0);
        rst = 1'b0;
        tick();
        check_out("first_gnt", 8'h01, 1'b1, 3'd0, 4'd1);

        // Full rotation with req held at FF.
        for (int j = 1; j <= 32; j++) begin
            tick();
            s = 3'((j / 4) % 8);
            check($sformatf("rot%0d.sel", j), 32'(sel), 32'(s));
            check($sformatf("rot%0d.hold", j), 32'(hold_cnt), 32'((j % 4) + 1));
            check($sformatf("rot%0d.gnt", j), 32'(gnt), 32'(8'h01 << s));
            check($sformatf("rot%0d.onehot", j), 32'($countones(gnt)), 32'd1);
        end

        // Early release hands off with no bubble.
        do_reset();
        req = 8'h24;
        tick();
        check_out("er_g1", 8'h04, 1'b1, 3'd2, 4'd1);
        tick();
        check_out("er_g2", 8'h04, 1'b1, 3'd2, 4'd2);
        req = 8'h20;
        tick();
        check_out("er_hand", 8'h20, 1'b1, 3'd5, 4'd1);

        // Sole requester keeps the grant; hold_cnt reloads after the quota.
        do_reset();
        req = 8'h80;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out($sformatf("sole%0d", i), 8'h80, 1'b1, 3'd7, 4'((i % 4) + 1));
        end
        req = 8'h00;
        tick();
        check_out("sole_idle", 8'h00, 1'b0, 3'd7, 4'd0);

        // Wrap-around: forced rotation from 6 searches 7,0 and comes back.
        do_reset();
        req = 8'h40;
        tick();
        check_out("wrap_own6", 8'h40, 1'b1, 3'd6, 4'd1);
        req = 8'h41;
        for (int k = 0; k < 8; k++) begin
            tick();
            s = 3'(w_sel[k]);
            check_out($sformatf("wrap%0d", k), 8'h01 << s, 1'b1, s, 4'(w_hold[k]));
        end

        // Reset in the middle of a grant.
        do_reset();
        req = 8'h08;
        tick();
        check_out("mid_g1", 8'h08, 1'b1, 3'd3, 4'd1);
        tick();
        check_out("mid_g2", 8'h08, 1'b1, 3'd3, 4'd2);
        rst = 1'b1;
        tick();
        check_out("mid_rst", 8'h00, 1'b0, 3'd0, 4'd0);
        rst = 1'b0;
        tick();
        check_out("mid_regnt", 8'h08, 1'b1, 3'd3, 4'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares the 8-input `mux8to1` between eight requesters by driving its 3-bit `sel` and reporting which requester owns the output `Q`. Each requester holds a level request. The arbiter grants one owner at a time, lets it keep the mux for a bounded number of cycles, then rotates fairly. It sits directly in front of `mux8to1`; `sel` connects straight to the mux select.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive cycles one owner keeps the grant while other requests are pending; legal range 1..15.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 8: level request, bit i = requester i (i=0 is mux input A, i=7 is H).
- `gnt` output 8: one-hot grant, registered; all zero when idle.
- `gnt_valid` output 1: high when exactly one `gnt` bit is set.
- `sel` output 3: binary index of the current owner, registered; drives `mux8to1.sel`.
- `hold_cnt` output 4: cycles the current owner has held the grant, 1-based; 0 when idle.

## Operation
- Two states:
  - IDLE: `gnt_valid`=0.
  - GRANT: `gnt_valid`=1.
- Priority pointer `last` (3 bits) holds the most recent owner. The search order is `last+1`, `last+2`, … `last+8`, taken modulo 8, so `last` itself is checked last.
- IDLE:
  - If `req`≠0, grant the first set bit in search order.
  - Then go to GRANT, set `hold_cnt`=1 and set `last` = the new owner.
  - If `req`=0, stay in IDLE.
- GRANT, owner `o`, evaluated every cycle on sampled `req`:
  - `req[o]`=0 (release):
    - If other requests are pending, grant the next requester in search order from `o+1` with no idle cycle.
    - Otherwise go to IDLE.
  - `req[o]`=1, `hold_cnt` < `HOLD_MAX`: keep owner; `hold_cnt`+1.
  - `req[o]`=1, `hold_cnt` = `HOLD_MAX`, other bits set: forced rotation to the next requester in search order from `o+1`; `o` is excluded this cycle.
  - `req[o]`=1, `hold_cnt` = `HOLD_MAX`, no other bits set: keep owner; `hold_cnt` reloads to 1.
- On every new grant, `hold_cnt`=1 and `last` = the new owner.
- `sel` always equals the binary encoding of `gnt`. When idle, `sel` holds the last owner's index, so the mux output stays stable. `sel` is 0 after reset.
- `hold_cnt` saturates at `HOLD_MAX` and never exceeds it.

## Timing
- All outputs are registered. A `req` sampled at edge N is reflected in `gnt`/`sel`/`gnt_valid`/`hold_cnt` after edge N.
- Latency from IDLE with `req` asserted to `gnt` is 1 cycle.
- Handoff on release or forced rotation is 1 cycle, with no bubble. `gnt` never has two bits set and never shows a zero cycle between owners when another request is pending.
- Reset takes effect at the edge where `rst`=1, including mid-grant. Values after reset:
  - `gnt`=0, `gnt_valid`=0, `sel`=0, `hold_cnt`=0
  - state=IDLE, `last`=7, so requester 0 has top priority on the first arbitration.
- `req` is ignored while `rst`=1. The first arbitration uses `req` sampled at the first edge with `rst`=0.
- Simultaneous release by the owner and a new request from another requester in the same cycle: the new requester is granted at the next edge.
- A requester that drops `req` before being granted is simply skipped. No request is latched.

## Test plan
- Reset/idle: `rst`=1 for 2 cycles with `req`=8'hFF, then `rst`=0. Required: `gnt`=0, `sel`=0, `hold_cnt`=0 while in reset; one cycle later `gnt`=8'h01, `sel`=0, `hold_cnt`=1.
- Rotation, `HOLD_MAX`=4, `req`=8'hFF held constant:
  - `sel` sequence: 0,0,0,0,1,1,1,1,2,…,7,7,7,7,0.
  - `hold_cnt` sequence: 1,2,3,4 for each owner.
  - `gnt` is always one-hot.
- Early release: `req`=8'h24 (bits 2 and 5) from IDLE. Required: owner 2. Drop `req[2]` after 2 grant cycles. Required: the next cycle `gnt`=8'h20, `sel`=5, `hold_cnt`=1, with no zero-`gnt` cycle.
- Sole requester beyond quota: `req`=8'h80 for 10 cycles. Required: `gnt`=8'h80 throughout, `sel`=7, `hold_cnt` = 1,2,3,4,1,2,3,4,1,2. Then `req`=0. Required: one cycle later `gnt`=0, `gnt_valid`=0, `sel` stays 7.
- Wrap-around fairness: own requester 6, then `req`=8'h41 (bits 0 and 6) held. Required: after the quota expires, the grant goes to 0 (search 7,0,…), then back to 6 after 4 cycles.
- Reset mid-operation: during a grant to 3 with `hold_cnt`=2, assert `rst` for 1 cycle with `req`=8'h08. Required: next cycle all outputs at reset values; following cycle `gnt`=8'h08, `hold_cnt`=1.
